// File: rtl/radix_multiplier.sv
// Multi-cycle shift-add multiplier: retires DIGIT multiplier bits per cycle and
// produces a full 2*WIDTH-bit signed or unsigned product after WIDTH/DIGIT cycles.
module radix_multiplier #(
    parameter int WIDTH = 256,
    parameter int DIGIT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 signed_in,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   c_out,
    output logic                 valid_out,
    output logic                 busy_out
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam int SW = $clog2(WIDTH) + 1;
    localparam int PW = WIDTH + DIGIT;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("radix_multiplier: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   c_q, c_d;
    logic                 valid_q, valid_d;
    logic                 busy_s;

    logic                 last_s;
    logic [SW-1:0]        shamt_s;
    logic [PW-1:0]        a_ext_s;
    logic [PW-1:0]        d_ext_s;
    logic [PW-1:0]        pp_s;
    logic [2*WIDTH-1:0]   pp_sh_s;
    logic [2*WIDTH-1:0]   sum_s;
    logic [2*WIDTH-1:0]   prod_s;

    // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + WIDTH'(1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // The multiplier register shifts right each cycle, so the current digit is always its LSBs.
    assign last_s  = (cnt_q == LAST_CNT);
    assign shamt_s = SW'(cnt_q) * SW'(DIGIT);
    assign a_ext_s = PW'(a_q);
    assign d_ext_s = PW'(b_q[DIGIT-1:0]);
    assign pp_s    = a_ext_s * d_ext_s;
    assign pp_sh_s = (2*WIDTH)'(pp_s) << shamt_s;
    assign sum_s   = acc_q + pp_sh_s;
    assign prod_s  = neg_q ? (~sum_s + (2*WIDTH)'(1)) : sum_s;

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = COMPUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = COMPUTE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next-value logic.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        valid_d = 1'b0;
        busy_s  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_s = 1'b0;
                if (valid_in) begin
                    a_d   = magnitude(a_in, signed_in);
                    b_d   = magnitude(b_in, signed_in);
                    neg_d = signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    a_d = a_q;
                end
            end
            COMPUTE: begin
                busy_s = 1'b1;
                acc_d  = sum_s;
                cnt_d  = cnt_q + CW'(1);
                b_d    = b_q >> DIGIT;
                if (last_s) begin
                    c_d     = prod_s;
                    valid_d = 1'b1;
                end else begin
                    c_d     = c_q;
                    valid_d = 1'b0;
                end
            end
            default: begin
                busy_s  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign c_out     = c_q;
    assign valid_out = valid_q;
    assign busy_out  = busy_s;

endmodule

// File: tb/tb_radix_multiplier.sv
// Directed bench for radix_multiplier: small 8-bit configurations with hand-computed
// products plus a 256-bit sweep compared against a sign-extension reference model.
module tb_radix_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [7:0]   a8, b8;
    logic         sgn8;
    logic [2:0]   v8, vo8, bz8;
    logic [15:0]  c_d2, c_d1, c_d8;

    logic [255:0] a256, b256;
    logic         s256, v256, vo256, bz256;
    logic [511:0] c256;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    radix_multiplier #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a8), .b_in(b8), .signed_in(sgn8),
        .valid_in(v8[0]), .c_out(c_d2), .valid_out(vo8[0]), .busy_out(bz8[0]));
    radix_multiplier #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a8), .b_in(b8), .signed_in(sgn8),
        .valid_in(v8[1]), .c_out(c_d1), .valid_out(vo8[1]), .busy_out(bz8[1]));
    radix_multiplier #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a8), .b_in(b8), .signed_in(sgn8),
        .valid_in(v8[2]), .c_out(c_d8), .valid_out(vo8[2]), .busy_out(bz8[2]));
    radix_multiplier #(.WIDTH(256), .DIGIT(4)) u_w256 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a256), .b_in(b256), .signed_in(s256),
        .valid_in(v256), .c_out(c256), .valid_out(vo256), .busy_out(bz256));

    function automatic logic [15:0] c8(input int idx);
        logic [15:0] r;
        case (idx)
            0:       r = c_d2;
            1:       r = c_d1;
            default: r = c_d8;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b, input logic s);
        logic [511:0] ea, eb;
        if (s) begin
            ea = {{256{a[255]}}, a};
            eb = {{256{b[255]}}, b};
        end else begin
            ea = {256'd0, a};
            eb = {256'd0, b};
        end
        return ea * eb;
    endfunction

    function automatic logic [255:0] pick256();
        logic [255:0] r;
        case ($urandom_range(0, 7))
            0:       r = 256'd0;
            1:       r = {1'b1, 255'd0};
            2:       r = {256{1'b1}};
            3:       r = 256'd1;
            4:       r = {1'b0, {255{1'b1}}};
            default: for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        endcase
        return r;
    endfunction

    // One transaction on an 8-bit instance; operands are scrambled after accept.
    task automatic run8(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input int lat, input string tag);
        int busy_cnt;
        int seen;
        @(negedge clk);
        a8 = a; b8 = b; sgn8 = s; v8[idx] = 1'b1;
        @(negedge clk);
        v8[idx] = 1'b0; a8 = ~a; b8 = ~b; sgn8 = ~s;
        busy_cnt = bz8[idx] ? 1 : 0;
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (vo8[idx]) seen = k;
            else if (bz8[idx]) busy_cnt++;
        end
        check({tag, " latency"}, 512'(seen), 512'(lat));
        check({tag, " product"}, 512'(c8(idx)), 512'(exp));
        check({tag, " busy cycles"}, 512'(busy_cnt), 512'(lat));
        check({tag, " busy at result"}, 512'(bz8[idx]), 512'(1'b0));
        @(negedge clk);
        check({tag, " pulse width"}, 512'(vo8[idx]), 512'(1'b0));
        check({tag, " held"}, 512'(c8(idx)), 512'(exp));
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int seen;
        logic [255:0] ta, tb;
        logic         ts;
        logic [511:0] texp;

        rst_n = 1'b0; v8 = 3'b000; v256 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; sgn8 = 1'b0;
        a256 = 256'd0; b256 = 256'd0; s256 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset c d2", 512'(c_d2), 512'd0);
        check("reset c w256", c256, 512'd0);
        check("reset valid", 512'({vo8, vo256}), 512'd0);
        check("reset busy", 512'({bz8, bz256}), 512'd0);
        rst_n = 1'b1;

        run8(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, "d2 255x255");
        run8(0, 8'h80, 8'h80, 1'b1, 16'h4000, 4, "d2 s -128x-128");
        run8(0, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 4, "d2 s -3x5");
        run8(0, 8'hFD, 8'h05, 1'b0, 16'h04F1, 4, "d2 u 253x5");

        // Back-to-back with valid held high; second accept lands on the valid_out cycle.
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0; v8[0] = 1'b1;
        @(negedge clk);
        a8 = 8'd11; b8 = 8'd13;
        check("b2b busy E0", 512'(bz8[0]), 512'(1'b1));
        repeat (3) @(negedge clk);
        check("b2b no early valid", 512'(vo8[0]), 512'(1'b0));
        @(negedge clk);
        check("b2b first valid", 512'(vo8[0]), 512'(1'b1));
        check("b2b first product", 512'(c_d2), 512'(16'd63));
        check("b2b idle at E4", 512'(bz8[0]), 512'(1'b0));
        @(negedge clk);
        v8[0] = 1'b0;
        check("b2b accept E5", 512'(bz8[0]), 512'(1'b1));
        check("b2b valid dropped", 512'(vo8[0]), 512'(1'b0));
        repeat (3) @(negedge clk);
        check("b2b c held in compute", 512'(c_d2), 512'(16'd63));
        check("b2b no valid E8", 512'(vo8[0]), 512'(1'b0));
        @(negedge clk);
        check("b2b second valid", 512'(vo8[0]), 512'(1'b1));
        check("b2b second product", 512'(c_d2), 512'(16'd143));
        @(negedge clk);

        // Reset at E2 of an in-flight 200x100.
        a8 = 8'd200; b8 = 8'd100; sgn8 = 1'b0; v8[0] = 1'b1;
        @(negedge clk);
        v8[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst c cleared", 512'(c_d2), 512'd0);
        check("midrst busy", 512'(bz8[0]), 512'(1'b0));
        check("midrst valid", 512'(vo8[0]), 512'(1'b0));
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (vo8[0]) pulses++;
        end
        check("midrst no pulse", 512'(pulses), 512'd0);
        run8(0, 8'd3, 8'd4, 1'b0, 16'd12, 4, "d2 after reset 3x4");

        run8(1, 8'd0, 8'd173, 1'b0, 16'd0, 8, "d1 0x173");
        run8(1, 8'd1, 8'd173, 1'b0, 16'd173, 8, "d1 1x173");
        run8(1, 8'hFF, 8'hFF, 1'b1, 16'h0001, 8, "d1 s -1x-1");
        run8(2, 8'd17, 8'd15, 1'b0, 16'd255, 1, "d8 17x15");
        run8(2, 8'h80, 8'h7F, 1'b1, 16'hC080, 1, "d8 s -128x127");

        for (int i = 0; i < 1000; i++) begin
            case (i)
                0:       begin ta = {1'b1, 255'd0};  tb = {1'b1, 255'd0};  ts = 1'b1; end
                1:       begin ta = {256{1'b1}};     tb = {256{1'b1}};     ts = 1'b0; end
                2:       begin ta = {256{1'b1}};     tb = {256{1'b1}};     ts = 1'b1; end
                3:       begin ta = 256'd0;          tb = {1'b1, 255'd0};  ts = 1'b1; end
                4:       begin ta = {1'b1, 255'd0};  tb = {256{1'b1}};     ts = 1'b0; end
                default: begin ta = pick256();       tb = pick256();       ts = 1'($urandom_range(0, 1)); end
            endcase
            texp = ref_mul(ta, tb, ts);
            @(negedge clk);
            a256 = ta; b256 = tb; s256 = ts; v256 = 1'b1;
            @(negedge clk);
            v256 = 1'b0; a256 = ~ta; b256 = ~tb; s256 = ~ts;
            seen = 0;
            for (int k = 1; k <= 80 && seen == 0; k++) begin
                @(negedge clk);
                if (vo256) seen = k;
            end
            check($sformatf("w256 #%0d latency", i), 512'(seen), 512'd64);
            check($sformatf("w256 #%0d product", i), c256, texp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/radix_multiplier.md
# radix_multiplier

Parametrised multi-cycle shift-add multiplier producing a full 2·WIDTH-bit product from two WIDTH-bit operands. It retires DIGIT multiplier bits per cycle, selectable from 1 (bit-serial) up to WIDTH (single-cycle array). It supports unsigned or two's-complement signed operation per transaction, and latches operands at acceptance so upstream may change inputs while busy. It is the big-integer multiply primitive for the modular-arithmetic datapath.

## Interface
Parameters:
- WIDTH, 256, operand width in bits; ≥ 2.
- DIGIT, 4, multiplier bits consumed per compute cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- a_in  input  WIDTH  multiplicand; sampled only on accept.
- b_in  input  WIDTH  multiplier; sampled only on accept.
- signed_in  input  1  1 = treat a_in/b_in as two's complement; sampled on accept.
- valid_in  input  1  request strobe.
- c_out  output  2·WIDTH  product; held stable until the next result is written.
- valid_out  output  1  one-cycle pulse when c_out is updated.
- busy_out  output  1  high while a transaction is in flight; accept = valid_in & !busy_out.

## Operation
- Let N = WIDTH/DIGIT. Internal registers:
  - |a| (WIDTH bits), |b| (WIDTH bits), neg flag.
  - Accumulator acc (2·WIDTH bits).
  - Digit counter cnt (clog2(N)+1 bits, to cover N=1).
- States:
  - IDLE: on accept, go to COMPUTE.
    - Latch |a|, |b| (magnitudes if signed_in, raw otherwise).
    - Latch neg = signed_in & (a[W-1] ^ b[W-1]).
    - Set acc = 0, cnt = 0, busy_out = 1.
  - COMPUTE: each cycle, acc += (|a| × |b|[cnt·DIGIT +: DIGIT]) << (cnt·DIGIT); cnt += 1.
    - Partial product is WIDTH+DIGIT bits; the sum is truncated to 2·WIDTH, which never overflows.
    - On the cycle with cnt == N-1, do the final add and write c_out = neg ? −(acc+pp) : (acc+pp), computed mod 2^(2W).
    - On the same cycle, set valid_out = 1 and busy_out = 0, and return to IDLE.
- valid_out is cleared on the following cycle unconditionally.
- valid_in while busy_out = 1 is ignored: no queueing and no effect on the in-flight result.
- Signed edge case: magnitude of −2^(W−1) is 2^(W−1), representable in WIDTH unsigned bits.
  - (−2^(W−1))² = 2^(2W−2) is a correct positive 2W-bit result.
- signed_in = 0: operands are pure unsigned; maximum product (2^W−1)² fits in 2W bits.

## Timing
- Reset (rst_n_in low at an edge):
  - State → IDLE.
  - c_out = 0, valid_out = 0, busy_out = 0, acc = 0, cnt = 0.
- Reset dominates any simultaneous valid_in.
- Reset mid-COMPUTE abandons the transaction: no valid_out, and c_out is cleared to 0.
- Accept at edge E0 ⇒ busy_out high from E0 to EN; c_out/valid_out registered at edge EN.
  - Latency = N cycles from accept edge to valid_out.
- Earliest next accept is edge EN+1, which coincides with the valid_out-high cycle.
  - Throughput is one result per N+1 cycles.
- DIGIT = WIDTH (N = 1): valid_out at E1.
- c_out holds its value through IDLE and through a following COMPUTE until overwritten at that transaction's final edge.

## Test plan
- WIDTH=8, DIGIT=2, unsigned 255×255 → c_out = 0xFE01, valid_out one pulse exactly 4 edges after accept, busy_out high for those 4 cycles.
- Same config, signed −128×−128 (0x80, 0x80) → 0x4000; signed −3×5 (0xFD, 0x05) → 0xFFF1; unsigned 0xFD×0x05 → 0x04F1.
- Back-to-back: accept 7×9, hold valid_in high continuously → first result 63 at E4. Second request is not accepted during busy (inputs changed mid-flight have no effect on 63). Next accept occurs at E5 with the new operands.
- Reset mid-op: accept 200×100, pull rst_n_in low at E2 → valid_out never pulses, c_out = 0, busy_out = 0. Next accept 3×4 → 12 after 4 cycles.
- Zero and identity with DIGIT=1, WIDTH=8: 0×173 → 0, 1×173 → 173, latency 8. DIGIT=8 (N=1): 17×15 → 255 at E1.
- WIDTH=256, DIGIT=4: 1000 random signed/unsigned pairs including ±2^255, 2^256−1 and 0, checked against a reference model; latency always 64.
